// File: rtl/fpu_mul_scheduler.sv
// Two-requester scheduler sharing one combinational single-precision multiplier.
// Latency: operand handshake in cycle N gives resp_valid in cycle N+2; one op in flight, so a new grant is possible every 3 cycles.
// Backpressure: the result is held in RESP until resp_ready; both requester readies stay low until the block is back in IDLE.
//
// Ports:
//   clk, rst                        rising-edge clock, synchronous active-high reset
//   req{0,1}_valid/_a/_b/_ready     requester operand handshakes (IEEE-754 single)
//   resp_valid/_ready               result handshake
//   resp_data, resp_id              product bits and owning requester index
//   resp_nan/_inf/_zero             classification of resp_data
//   op_count                        completed responses, saturating at all-ones

// Combinational IEEE-754 single-precision multiplier.
// Round-to-nearest-even; subnormal inputs and results are flushed to signed zero;
// any NaN or inf*0 yields the canonical quiet NaN 0x7FC00000.
module fpu_sp_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] c
);

  logic              sa, sb, sc;
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]       prod;
  logic              norm, guard, sticky, round_up, carry;
  logic [22:0]       frac_r;
  logic [23:0]       frac_rnd;
  logic signed [9:0] e_fin;

  always_comb begin
    sa       = a[31];
    sb       = b[31];
    ea       = a[30:23];
    eb       = b[30:23];
    fa       = a[22:0];
    fb       = b[22:0];
    sc       = sa ^ sb;
    a_nan    = (ea == 8'hFF) && (fa != 23'd0);
    b_nan    = (eb == 8'hFF) && (fb != 23'd0);
    a_inf    = (ea == 8'hFF) && (fa == 23'd0);
    b_inf    = (eb == 8'hFF) && (fb == 23'd0);
    // Exponent zero covers both true zero and flushed subnormals.
    a_zero   = (ea == 8'h00);
    b_zero   = (eb == 8'h00);

    prod     = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
    // Product of two [1,2) significands lies in [1,4); bit 47 set means [2,4).
    norm     = prod[47];
    if (norm) begin
      frac_r = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac_r = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    round_up = guard & (sticky | frac_r[0]);
    frac_rnd = {1'b0, frac_r} + {23'd0, round_up};
    // Rounding out of an all-ones fraction bumps the exponent; fraction wraps to 0.
    carry    = frac_rnd[23];
    e_fin    = $signed({2'b00, ea}) + $signed({2'b00, eb})
             + $signed({9'd0, norm}) + $signed({9'd0, carry}) - 10'sd127;

    c = 32'd0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      c = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      c = {sc, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      c = {sc, 31'd0};
    end else if (e_fin >= 10'sd255) begin
      c = {sc, 8'hFF, 23'd0};
    end else if (e_fin <= 10'sd0) begin
      c = {sc, 31'd0};
    end else begin
      c = {sc, e_fin[7:0], frac_rnd[22:0]};
    end
  end

endmodule

module fpu_mul_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_id,
  output logic             resp_nan,
  output logic             resp_inf,
  output logic             resp_zero,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic       cur_id;
  logic [31:0] op_a, op_b, res, mul_c;
  logic       gnt_vld, gnt_id;
  logic [7:0] res_exp;
  logic [22:0] res_mant;

  fpu_sp_multiplier u_mul (
    .a (op_a),
    .b (op_b),
    .c (mul_c)
  );

  always_comb begin
    gnt_vld   = 1'b0;
    gnt_id    = 1'b0;
    state_nxt = state;

    // Grants are suppressed during reset so no handshake is ever seen then.
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end

    case (state)
      IDLE:    if (gnt_vld) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = gnt_vld && !gnt_id;
  assign req1_ready = gnt_vld &&  gnt_id;

  assign res_exp    = res[30:23];
  assign res_mant   = res[22:0];

  // Response outputs are forced to zero outside RESP and while reset is asserted.
  assign resp_valid = (state == RESP) && !rst;
  assign resp_data  = resp_valid ? res    : 32'd0;
  assign resp_id    = resp_valid && cur_id;
  assign resp_nan   = resp_valid && (res_exp == 8'hFF) && (res_mant != 23'd0);
  assign resp_inf   = resp_valid && (res_exp == 8'hFF) && (res_mant == 23'd0);
  assign resp_zero  = resp_valid && (res_exp == 8'h00) && (res_mant == 23'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= 32'd0;
      op_b       <= 32'd0;
      res        <= 32'd0;
      cur_id     <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= state_nxt;
      if (gnt_vld) begin
        op_a       <= gnt_id ? req1_a : req0_a;
        op_b       <= gnt_id ? req1_b : req0_b;
        cur_id     <= gnt_id;
        last_grant <= gnt_id;
      end
      if (state == CALC) begin
        res <= mul_c;
      end
      if (resp_valid && resp_ready && (op_count != {CNT_W{1'b1}})) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpu_mul_scheduler.sv
module tb_fpu_mul_scheduler;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready;
  logic             resp_valid, resp_ready;
  logic [31:0]      resp_data;
  logic             resp_id, resp_nan, resp_inf, resp_zero;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  fpu_mul_scheduler #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_nan   (resp_nan),
    .resp_inf   (resp_inf),
    .resp_zero  (resp_zero),
    .op_count   (op_count)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        nan;
    logic        inf;
    logic        zero;
  } rsp_t;

  rsp_t             exp_q[$];
  rsp_t             got_q[$];
  int               hs_cyc_q[$];
  int               rsp_cyc_q[$];
  int               cyc;
  int               errors;
  int               checks;
  logic [CNT_W-1:0] exp_cnt;
  logic [31:0]      prod0, prod1;
  bit               both_rdy;

  // Expected response for a product, flags classified from the IEEE fields.
  function automatic rsp_t mk(input logic id, input logic [31:0] d);
    rsp_t r;
    r.id   = id;
    r.data = d;
    r.nan  = (d[30:23] == 8'hFF) && (d[22:0] != 23'd0);
    r.inf  = (d[30:23] == 8'hFF) && (d[22:0] == 23'd0);
    r.zero = (d[30:23] == 8'h00) && (d[22:0] == 23'd0);
    return r;
  endfunction

  // One clock: sample handshakes at negedge, then move to just after the posedge.
  task automatic step();
    rsp_t g;
    @(negedge clk);
    if (req0_ready && req1_ready) both_rdy = 1'b1;
    if (req0_valid && req0_ready) begin
      exp_q.push_back(mk(1'b0, prod0));
      hs_cyc_q.push_back(cyc);
    end
    if (req1_valid && req1_ready) begin
      exp_q.push_back(mk(1'b1, prod1));
      hs_cyc_q.push_back(cyc);
    end
    if (resp_valid && resp_ready) begin
      g.id   = resp_id;
      g.data = resp_data;
      g.nan  = resp_nan;
      g.inf  = resp_inf;
      g.zero = resp_zero;
      got_q.push_back(g);
      rsp_cyc_q.push_back(cyc);
    end
    if (rst) exp_cnt = '0;
    else if (resp_valid && resp_ready && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] p, output bit ok);
    int n0;
    n0 = hs_cyc_q.size();
    if (id == 1'b0) begin
      req0_a = a; req0_b = b; prod0 = p; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; prod1 = p; req1_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (hs_cyc_q.size() != n0) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ok = (hs_cyc_q.size() != n0);
  endtask

  task automatic drain(output bit ok);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == got_q.size()) break;
      step();
    end
    ok = (exp_q.size() == got_q.size());
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'h4000_0000; req0_b = 32'h4000_0000;
    req1_a = 32'h4000_0000; req1_b = 32'h4000_0000;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got=%b want=0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got=%b want=0", req1_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
    checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL reset_resp_id got=%b want=0", resp_id); end
    checks++; if ({resp_nan, resp_inf, resp_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {resp_nan, resp_inf, resp_zero}); end
    @(posedge clk); #1;
    checks++; if (op_count !== '0) begin errors++; $display("FAIL reset_op_count got=%0d want=0", op_count); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_cnt = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    rsp_t g, e;
    hs_cyc_q.delete(); rsp_cyc_q.delete();
    resp_ready = 1'b1;
    send(1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_grant timeout got=none want=grant"); end
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_resp timeout got=%0d want=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL single_resp got id=%0d data=%h nif=%b%b%b want id=%0d data=%h nif=%b%b%b", g.id, g.data, g.nan, g.inf, g.zero, e.id, e.data, e.nan, e.inf, e.zero); end
    end
    checks++;
    if (hs_cyc_q.size() < 1 || rsp_cyc_q.size() < 1 || rsp_cyc_q[0] - hs_cyc_q[0] != 2) begin
      errors++; $display("FAIL single_latency got=%0d want=2", (hs_cyc_q.size() > 0 && rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] - hs_cyc_q[0] : -1);
    end
    checks++; if (op_count !== 4'd1) begin errors++; $display("FAIL single_op_count got=%0d want=1", op_count); end
  endtask

  task automatic test_contention();
    bit ok;
    rsp_t g, e;
    apply_reset();
    hs_cyc_q.delete(); rsp_cyc_q.delete();
    both_rdy = 1'b0;
    resp_ready = 1'b1;
    req0_a = 32'h3FC0_0000; req0_b = 32'hC000_0000; prod0 = 32'hC040_0000;
    req1_a = 32'h0000_0000; req1_b = 32'h4000_0000; prod1 = 32'h0000_0000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 40 && got_q.size() < 3; i++) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(ok);
    checks++; if (!ok || got_q.size() < 3) begin errors++; $display("FAIL contention_count got=%0d want>=3", got_q.size()); end
    for (int k = 0; k < 3 && k < got_q.size(); k++) begin
      checks++;
      if (got_q[k].id !== k[0]) begin errors++; $display("FAIL contention_order idx=%0d got=%0d want=%0d", k, got_q[k].id, k[0]); end
    end
    if (got_q.size() >= 2) begin
      checks++;
      if (got_q[1].zero !== 1'b1) begin errors++; $display("FAIL contention_zero_flag got=%b want=1", got_q[1].zero); end
    end
    for (int k = 1; k < 3 && k < hs_cyc_q.size(); k++) begin
      checks++;
      if (hs_cyc_q[k] - hs_cyc_q[k-1] != 3) begin errors++; $display("FAIL contention_spacing idx=%0d got=%0d want=3", k, hs_cyc_q[k] - hs_cyc_q[k-1]); end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL contention_resp got id=%0d data=%h nif=%b%b%b want id=%0d data=%h nif=%b%b%b", g.id, g.data, g.nan, g.inf, g.zero, e.id, e.data, e.nan, e.inf, e.zero); end
    end
    checks++; if (both_rdy !== 1'b0) begin errors++; $display("FAIL contention_both_ready got=1 want=0"); end
    checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL contention_op_count got=%0d want=%0d", op_count, exp_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    rsp_t g, e;
    logic [CNT_W-1:0] cnt0;
    hs_cyc_q.delete();
    resp_ready = 1'b0;
    send(1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_grant timeout got=none want=grant"); end
    for (int i = 0; i < 10 && !resp_valid; i++) step();
    cnt0 = exp_cnt;
    req1_a = 32'h3F80_0000; req1_b = 32'h3F80_0000; prod1 = 32'h3F80_0000;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, resp_valid); end
      checks++; if (resp_data !== 32'h40C0_0000) begin errors++; $display("FAIL bp_data cyc=%0d got=%h want=40c00000", i, resp_data); end
      checks++; if (resp_id !== 1'b0) begin errors++; $display("FAIL bp_id cyc=%0d got=%b want=0", i, resp_id); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b want=00", i, {req0_ready, req1_ready}); end
      checks++; if (op_count !== cnt0) begin errors++; $display("FAIL bp_op_count cyc=%0d got=%0d want=%0d", i, op_count, cnt0); end
      step();
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 20 && hs_cyc_q.size() < 2; i++) step();
    req1_valid = 1'b0;
    drain(ok);
    checks++; if (!ok || got_q.size() != 2) begin errors++; $display("FAIL bp_drain got=%0d want=2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL bp_resp got id=%0d data=%h nif=%b%b%b want id=%0d data=%h nif=%b%b%b", g.id, g.data, g.nan, g.inf, g.zero, e.id, e.data, e.nan, e.inf, e.zero); end
    end
    checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL bp_op_count_end got=%0d want=%0d", op_count, exp_cnt); end
  endtask

  task automatic test_special();
    bit ok;
    rsp_t g, e;
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic [31:0] tp [5];
    ta = '{32'h7F80_0000, 32'h7FC0_0000, 32'h3F80_0000, 32'h7F00_0000, 32'hBF80_0000};
    tb = '{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 32'h4000_0000, 32'h3F80_0000};
    tp = '{32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h7F80_0000, 32'hBF80_0000};
    resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(k[0], ta[k], tb[k], tp[k], ok);
      drain(ok);
      checks++; if (!ok || got_q.size() != 1) begin errors++; $display("FAIL special_resp idx=%0d got=%0d want=1", k, got_q.size()); end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (g !== e) begin errors++; $display("FAIL special_resp idx=%0d got id=%0d data=%h nif=%b%b%b want id=%0d data=%h nif=%b%b%b", k, g.id, g.data, g.nan, g.inf, g.zero, e.id, e.data, e.nan, e.inf, e.zero); end
      end
    end
  endtask

  task automatic test_saturate();
    bit ok;
    rsp_t g, e;
    apply_reset();
    resp_ready = 1'b1;
    req0_a = 32'h4000_0000; req0_b = 32'h4040_0000; prod0 = 32'h40C0_0000;
    req0_valid = 1'b1;
    for (int i = 0; i < 100 && got_q.size() < 17; i++) step();
    req0_valid = 1'b0;
    drain(ok);
    checks++; if (!ok || got_q.size() < 17) begin errors++; $display("FAIL sat_count got=%0d want>=17", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL sat_resp got id=%0d data=%h want id=%0d data=%h", g.id, g.data, e.id, e.data); end
    end
    checks++; if (op_count !== 4'hF) begin errors++; $display("FAIL sat_op_count got=%0d want=15", op_count); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen_valid;
    rsp_t g, e;
    resp_ready = 1'b1;
    send(1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, ok);
    drain(ok);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL rmid_pre got id=%0d data=%h want id=%0d data=%h", g.id, g.data, e.id, e.data); end
    end
    send(1'b0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_grant timeout got=none want=grant"); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen_valid = 1'b1;
      step();
    end
    checks++; if (seen_valid || got_q.size() != 0) begin errors++; $display("FAIL rmid_no_resp got=1 want=0"); end
    checks++; if (op_count !== '0) begin errors++; $display("FAIL rmid_op_count got=%0d want=0", op_count); end
    req0_a = 32'h4000_0000; req0_b = 32'h4040_0000; prod0 = 32'h40C0_0000;
    req1_a = 32'h3F80_0000; req1_b = 32'h3F80_0000; prod1 = 32'h3F80_0000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() < 1; i++) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (exp_q.size() < 1 || exp_q[0].id !== 1'b0) begin errors++; $display("FAIL rmid_priority got=%0d want=0", exp_q.size() > 0 ? exp_q[0].id : 1'b1); end
    drain(ok);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL rmid_resp got id=%0d data=%h want id=%0d data=%h", g.id, g.data, e.id, e.data); end
    end
    checks++; if (op_count !== 4'd1) begin errors++; $display("FAIL rmid_op_count_end got=%0d want=1", op_count); end
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; exp_cnt = '0;
    prod0 = 32'd0; prod1 = 32'd0; both_rdy = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_special();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_mul_scheduler.md
FPU_MUL_SCHEDULER -- requirements
Module: fpu_mul_scheduler

Interface
REQ-001 Parameter: CNT_W, default 16, width of the completed-operation counter.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: req0_valid  input  1  requester 0 has an operand pair.
REQ-006 Port: req0_a, req0_b  input  32 each  requester 0 IEEE-754 single operands.
REQ-007 Port: req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-008 Port: req1_valid, req1_a, req1_b, req1_ready  same widths and meaning for requester 1.
REQ-009 Port: resp_valid  output  1  result held on resp_* outputs.
REQ-010 Port: resp_ready  input  1  consumer takes the result.
REQ-011 Port: resp_data  output  32  product bits.
REQ-012 Port: resp_id  output  1  requester index that owns the result.
REQ-013 Port: resp_nan, resp_inf, resp_zero  output  1 each  classification of resp_data.
REQ-014 Port: op_count  output  CNT_W  number of completed responses, saturating.

Function
REQ-015 Block SHALL instantiate exactly one fpu_sp_multiplier (ports a, b, c, combinational) and share it between both requesters.
REQ-016 FSM states SHALL be IDLE, CALC and RESP.
REQ-017 IDLE SHALL grant at most one requester per cycle; the granted requester's ready is high in that cycle only if its valid is high.
REQ-018 Arbitration SHALL be round-robin on last_grant:
- one valid: grant that requester;
- both valid: grant the requester not equal to last_grant.
REQ-019 On a grant, the block SHALL capture the operands into op_a/op_b, capture the index into cur_id, update last_grant, and go to CALC.
REQ-020 req0_ready and req1_ready SHALL be low in CALC and RESP; they are never high together.
REQ-021 CALC SHALL register the multiplier output c into res, compute the flags from res bits, and go to RESP next cycle.
REQ-022 Flag rules:
- nan = exp==0xFF and mant!=0;
- inf = exp==0xFF and mant==0;
- zero = exp==0 and mant==0.
REQ-023 RESP SHALL hold resp_valid high with resp_data=res and resp_id=cur_id, stable until the cycle in which resp_ready is high.
REQ-024 In RESP with resp_ready high, the block SHALL go to IDLE and increment op_count; op_count stays at all-ones once reached.
REQ-025 resp_valid SHALL be low in IDLE and CALC.
REQ-026 Latency: handshake at cycle N SHALL give resp_valid at N+2; minimum issue interval is 3 cycles.
REQ-027 Requester valid deasserting while not granted SHALL leave no trace; operands are sampled only on the grant cycle.
REQ-028 resp_ready high outside RESP SHALL be ignored.

Reset
REQ-029 While rst is high at a clk edge, the block SHALL set: state=IDLE, last_grant=1 (req0 wins first contention), op_a=op_b=res=0, cur_id=0, op_count=0.
REQ-030 During and after reset: resp_valid=0, resp_data=0, resp_id=0, all flags 0, both ready outputs low in the reset cycle.
REQ-031 Reset asserted in CALC or RESP SHALL abort the operation with no response and no count increment.

Verification
REQ-032 Single op: req0 0x40000000 * 0x40400000 at cycle N -> resp_valid at N+2, resp_data=0x40C00000, resp_id=0, flags 0, op_count=1.
REQ-033 Contention: both valid continuously, req0 0x3FC00000*0xC0000000, req1 0x00000000*0x40000000, resp_ready=1 -> responses in this order:
- id0 0xC0400000;
- id1 0x00000000 with resp_zero=1;
- id0 again;
- each grant 3 cycles apart.
REQ-034 Backpressure: resp_ready held low 5 cycles in RESP -> resp_data/resp_id stable, both ready low, op_count unchanged until release.
REQ-035 Special: 0x7F800000 * 0x3F800000 -> resp_data=0x7F800000 with resp_inf=1; 0x7FC00000 * 0x3F800000 -> resp_nan=1.
REQ-036 Reset mid-CALC: rst pulsed one cycle after the grant -> no resp_valid, op_count=0, next request served normally with req0 priority.
